// File: rtl/mul_seq_32.sv
// Multi-cycle unsigned shift-add multiplier controller: sequences one external
// WIDTH-bit adder for WIDTH iterations to form a 2*WIDTH-bit product.
module mul_seq_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    // Handshake: start is a level request sampled only in IDLE or DONE; done is a
    // one-cycle pulse, and prod_hi/prod_lo hold the result until the next accepted start.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d;
    logic [WIDTH-1:0] p_lo_q, p_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_LOAD;
                    m_d     = mcand;
                    p_lo_d  = mplier;
                    p_hi_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_ITER;
            end
            ST_ITER: begin
                // Add-then-shift: carry lands in the top bit, sum LSB drops into P_lo.
                p_hi_d = {add_cout, add_sum[WIDTH-1:1]};
                p_lo_d = {add_sum[0], p_lo_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q == ST_LOAD) || (state_q == ST_ITER);
    assign done    = (state_q == ST_DONE);
    assign prod_hi = p_hi_q;
    assign prod_lo = p_lo_q;
    assign add_a   = p_hi_q;
    assign add_b   = p_lo_q[0] ? m_q : '0;
    assign add_cin = 1'b0;

endmodule

// File: tb/tb_mul_seq_32.sv
// Bench for mul_seq_32: external adder modelled behaviourally, results checked
// against a 64-bit reference multiply held in an expected queue.
module tb_mul_seq_32;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    mul_seq_32 #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .prod_hi (prod_hi),
        .prod_lo (prod_lo),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_cin (add_cin),
        .add_sum (add_sum),
        .add_cout(add_cout)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start cycle and records the reference product; returns at the next negedge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        exp_q.push_back({32'b0, a} * {32'b0, b});
        @(negedge clk);
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
    endtask

    // Waits (bounded) for done, counting negedges from lat0 and busy cycles seen.
    task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
        lat      = lat0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        clr    = 1'b1;
        start  = 1'b1;
        mcand  = 32'hDEADBEEF;
        mplier = 32'h12345678;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done=%b required 00", {busy, done});
        end
        n_checks++;
        if ({prod_hi, prod_lo} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_prod: got %h required 0", {prod_hi, prod_lo});
        end
        n_checks++;
        if ({add_a, add_b, add_cin} !== 65'h0) begin
            n_fail++;
            $display("FAIL reset_adder: a=%h b=%h cin=%b required all 0", add_a, add_b, add_cin);
        end
        start = 1'b0;
        clr   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [63:0] exp;
        start_op(32'd3, 32'd5);
        wait_done(1, lat, bc);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat !== 34) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d required 34", lat);
        end
        n_checks++;
        if (bc !== 33) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d required 33", bc);
        end
        n_checks++;
        if ({prod_hi, prod_lo} !== 64'h0000_0000_0000_000F || exp !== 64'hF) begin
            n_fail++;
            $display("FAIL basic_prod: got %h required %h", {prod_hi, prod_lo}, exp);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || {prod_hi, prod_lo} !== exp) begin
            n_fail++;
            $display("FAIL basic_hold: done=%b prod=%h required done=0 prod=%h",
                     done, {prod_hi, prod_lo}, exp);
        end
    endtask

    task automatic test_all_ones();
        int lat, bc;
        logic [63:0] exp;
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, lat, bc);
        exp = exp_q.pop_front();
        n_checks++;
        if (prod_hi !== 32'hFFFF_FFFE || prod_lo !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL all_ones_prod: got %h_%h required fffffffe_00000001 (model %h)",
                     prod_hi, prod_lo, exp);
        end
    endtask

    task automatic test_zero();
        int lat, bc;
        logic [63:0] exp;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) start_op(32'h1234_5678, 32'h0);
            else        start_op(32'h0, 32'h1234_5678);
            wait_done(1, lat, bc);
            exp = exp_q.pop_front();
            n_checks++;
            if (lat !== 34) begin
                n_fail++;
                $display("FAIL zero_latency[%0d]: got %0d required 34", k, lat);
            end
            n_checks++;
            if ({prod_hi, prod_lo} !== exp) begin
                n_fail++;
                $display("FAIL zero_prod[%0d]: got %h required %h", k, {prod_hi, prod_lo}, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        logic [63:0] exp;
        start_op(32'h0000_ABCD, 32'h0001_2345);
        repeat (9) @(negedge clk);
        start  = 1'b1;
        mcand  = 32'hFFFF_0000;
        mplier = 32'h7777_7777;
        @(negedge clk);
        start  = 1'b0;
        wait_done(11, lat, bc);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat !== 34) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d required 34", lat);
        end
        n_checks++;
        if ({prod_hi, prod_lo} !== exp) begin
            n_fail++;
            $display("FAIL ignore_prod: got %h required %h", {prod_hi, prod_lo}, exp);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_requeue: busy=%b required 0", busy);
        end
    endtask

    task automatic test_clr_abort();
        int lat, bc, spurious;
        logic [63:0] exp;
        start_op(32'h0BAD_F00D, 32'hCAFE_1234);
        // Counter reaches 10 after the eleventh edge following acceptance.
        repeat (11) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        void'(exp_q.pop_front());
        n_checks++;
        if ({busy, done} !== 2'b00 || {prod_hi, prod_lo} !== 64'h0) begin
            n_fail++;
            $display("FAIL clr_abort_state: busy=%b done=%b prod=%h required 0/0/0",
                     busy, done, {prod_hi, prod_lo});
        end
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        n_checks++;
        if (spurious !== 0) begin
            n_fail++;
            $display("FAIL clr_abort_quiet: %0d active cycles required 0", spurious);
        end
        start_op(32'd1000, 32'd2000);
        wait_done(1, lat, bc);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat !== 34 || {prod_hi, prod_lo} !== exp) begin
            n_fail++;
            $display("FAIL clr_restart: lat=%0d prod=%h required 34 and %h",
                     lat, {prod_hi, prod_lo}, exp);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bc;
        logic [63:0] exp;
        @(negedge clk);
        start  = 1'b1;
        mcand  = 32'd7;
        mplier = 32'd9;
        exp_q.push_back(64'd63);
        @(negedge clk);
        wait_done(1, lat1, bc);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat1 !== 34 || {prod_hi, prod_lo} !== exp) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d prod=%h required 34 and %h",
                     lat1, {prod_hi, prod_lo}, exp);
        end
        mcand  = 32'h0001_0000;
        mplier = 32'h0001_0000;
        exp_q.push_back(64'h0000_0001_0000_0000);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_reaccept: busy=%b required 1", busy);
        end
        wait_done(1, lat2, bc);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat2 !== 34 || {prod_hi, prod_lo} !== exp) begin
            n_fail++;
            $display("FAIL b2b_second: gap=%0d prod=%h required 34 and %h",
                     lat2, {prod_hi, prod_lo}, exp);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [31:0] a, b;
        logic [63:0] exp;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin
                    a = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
                    b = $urandom;
                end
                2: begin a = $urandom_range(0, 255); b = $urandom_range(0, 255); end
                default: begin
                    a = 32'h1 << $urandom_range(0, 31);
                    b = $urandom | 32'h8000_0000;
                end
            endcase
            if ($urandom_range(0, 1) != 0) begin
                logic [31:0] t;
                t = a; a = b; b = t;
            end
            start_op(a, b);
            wait_done(1, lat, bc);
            exp = exp_q.pop_front();
            n_checks++;
            if (lat !== 34 || bc !== 33) begin
                n_fail++;
                $display("FAIL rand_timing[%0d]: lat=%0d busy=%0d required 34/33", i, lat, bc);
            end
            n_checks++;
            if ({prod_hi, prod_lo} !== exp || add_cin !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_prod[%0d]: %h*%h got %h cin=%b required %h cin=0",
                         i, a, b, {prod_hi, prod_lo}, add_cin, exp);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || {prod_hi, prod_lo} !== exp) begin
                n_fail++;
                $display("FAIL rand_hold[%0d]: done=%b prod=%h required 0 and %h",
                         i, done, {prod_hi, prod_lo}, exp);
            end
        end
    endtask

    initial begin
        clr    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        test_reset();
        test_basic();
        test_all_ones();
        test_zero();
        test_ignore_start();
        test_clr_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
